// File: rtl/csr_ctrl_if.sv
// Shared width parameters and the csr_ctrl bus interface. The interface carries
// the request/response handshake, the register-file write port, the TLB flush
// handshake and busy.
package params_pkg;
  parameter int DATA_WIDTH = 32;
  parameter int ADDR_WIDTH = 12;
endpackage

interface csr_ctrl_if #(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_illegal_o;
  logic                  csr_wr_en_o;
  logic [ADDR_WIDTH-1:0] csr_wr_addr_o;
  logic [DATA_WIDTH-1:0] csr_wr_data_o;
  logic [DATA_WIDTH-1:0] csr_satp_i;
  logic                  tlb_flush_req_o;
  logic                  tlb_flush_ack_i;
  logic                  busy_o;

  // controller side
  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_wdata_i, rsp_ready_i,
           csr_satp_i, tlb_flush_ack_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o,
           csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o, tlb_flush_req_o, busy_o
  );

  // execute stage / register file / TLB side
  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_wdata_i, rsp_ready_i,
           csr_satp_i, tlb_flush_ack_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_illegal_o,
           csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o, tlb_flush_req_o, busy_o
  );
endinterface

// File: rtl/csr_ctrl.sv
// CSR read-modify-write sequencer for satp with optional TLB flush handshake.
// Define CSR_CTRL_TLB_FLUSH_EN to enable the FLUSH state; otherwise WRITE goes straight to RESP.
module csr_ctrl #(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH
) (
  input  logic       clk_i,
  input  logic       rst_i,
  csr_ctrl_if.slave  bus
);

  localparam logic [11:0] SATP_ADDR = 12'h180;
  localparam logic [1:0]  OP_RW = 2'b01;
  localparam logic [1:0]  OP_RS = 2'b10;
  localparam logic [1:0]  OP_RC = 2'b11;

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH, RESP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] old_q;
  logic                  legal;
  logic                  do_write;
  logic [DATA_WIDTH-1:0] new_val;

  always_comb begin
    legal = (bus.req_op_i != 2'b00) && (bus.req_addr_i[11:0] == SATP_ADDR);
    case (bus.req_op_i)
      OP_RS:   new_val = bus.csr_satp_i | bus.req_wdata_i;
      OP_RC:   new_val = bus.csr_satp_i & ~bus.req_wdata_i;
      default: new_val = bus.req_wdata_i;
    endcase
    // set/clear with a zero operand is a pure read
    do_write = legal && ((bus.req_op_i == OP_RW) || (bus.req_wdata_i != '0));
  end

`ifndef CSR_CTRL_TLB_FLUSH_EN
  logic unused_ack;
  assign unused_ack = bus.tlb_flush_ack_i;
  assign bus.tlb_flush_req_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state             <= IDLE;
      old_q             <= '0;
      bus.req_ready_o   <= 1'b1;
      bus.rsp_valid_o   <= 1'b0;
      bus.rsp_rdata_o   <= '0;
      bus.rsp_illegal_o <= 1'b0;
      bus.csr_wr_en_o   <= 1'b0;
      bus.csr_wr_addr_o <= '0;
      bus.csr_wr_data_o <= '0;
      bus.busy_o        <= 1'b0;
`ifdef CSR_CTRL_TLB_FLUSH_EN
      bus.tlb_flush_req_o <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            old_q           <= bus.csr_satp_i;
            bus.req_ready_o <= 1'b0;
            bus.busy_o      <= 1'b1;
            if (do_write) begin
              state             <= WRITE;
              bus.csr_wr_en_o   <= 1'b1;
              bus.csr_wr_addr_o <= bus.req_addr_i;
              bus.csr_wr_data_o <= new_val;
            end else begin
              state             <= RESP;
              bus.rsp_valid_o   <= 1'b1;
              bus.rsp_rdata_o   <= legal ? bus.csr_satp_i : '0;
              bus.rsp_illegal_o <= !legal;
            end
          end
        end
        WRITE: begin
          bus.csr_wr_en_o   <= 1'b0;
          bus.csr_wr_addr_o <= '0;
          bus.csr_wr_data_o <= '0;
`ifdef CSR_CTRL_TLB_FLUSH_EN
          state               <= FLUSH;
          bus.tlb_flush_req_o <= 1'b1;
`else
          state           <= RESP;
          bus.rsp_valid_o <= 1'b1;
          bus.rsp_rdata_o <= old_q;
`endif
        end
`ifdef CSR_CTRL_TLB_FLUSH_EN
        FLUSH: begin
          if (bus.tlb_flush_ack_i) begin
            state               <= RESP;
            bus.tlb_flush_req_o <= 1'b0;
            bus.rsp_valid_o     <= 1'b1;
            bus.rsp_rdata_o     <= old_q;
          end
        end
`endif
        RESP: begin
          if (bus.rsp_ready_i) begin
            state             <= IDLE;
            bus.rsp_valid_o   <= 1'b0;
            bus.rsp_rdata_o   <= '0;
            bus.rsp_illegal_o <= 1'b0;
            bus.req_ready_o   <= 1'b1;
            bus.busy_o        <= 1'b0;
          end
        end
        default: begin
          state           <= IDLE;
          bus.req_ready_o <= 1'b1;
          bus.busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl; expectations follow CSR_CTRL_TLB_FLUSH_EN if defined.
module tb_csr_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   errors = 0;
  int   checks = 0;

  csr_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();
  csr_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // drive a request during cycle 0; returns positioned in cycle 1
  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wd;
    step();
    bus.req_valid_i = 1'b0;
    bus.req_wdata_i = 32'hDEAD_BEEF;
  endtask

  task automatic finish_rsp();
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 ||
        bus.rsp_rdata_o !== 32'h0 || bus.rsp_illegal_o !== 1'b0 || bus.csr_wr_en_o !== 1'b0 ||
        bus.csr_wr_addr_o !== 12'h0 || bus.csr_wr_data_o !== 32'h0 || bus.tlb_flush_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: rdy=%b busy=%b rv=%b rd=%h ill=%b we=%b wa=%h wd=%h fl=%b want rdy=1 rest 0",
               tag, bus.req_ready_o, bus.busy_o, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_illegal_o,
               bus.csr_wr_en_o, bus.csr_wr_addr_o, bus.csr_wr_data_o, bus.tlb_flush_req_o);
    end
  endtask

  task automatic test_reset();
    #22;
    check_idle("reset_hold");
    @(negedge clk_i); rst_i = 1'b1;
    #1;
    issue(2'b01, 12'h180, 32'h1);
    #2;
    rst_i = 1'b0;
    #1;
    check_idle("reset_async");
    @(negedge clk_i); rst_i = 1'b1;
    step();
  endtask

  // Write path: expect write at cycle 1, flush 2..4, ack in 4, response at 5
  task automatic test_rw_flush();
    bus.csr_satp_i = 32'h0;
    issue(2'b01, 12'h180, 32'h8000_1234);
    checks++;
    if (bus.csr_wr_en_o !== 1'b1 || bus.csr_wr_addr_o !== 12'h180 || bus.csr_wr_data_o !== 32'h8000_1234) begin
      errors++;
      $display("FAIL rw_write: we=%b wa=%h wd=%h want 1 180 80001234", bus.csr_wr_en_o, bus.csr_wr_addr_o, bus.csr_wr_data_o);
    end
    bus.csr_satp_i = 32'h8000_1234;
    step();
`ifdef CSR_CTRL_TLB_FLUSH_EN
    for (int c = 2; c <= 4; c++) begin
      checks++;
      if (bus.tlb_flush_req_o !== 1'b1 || bus.csr_wr_en_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
        errors++;
        $display("FAIL rw_flush c%0d: fl=%b we=%b rv=%b busy=%b want 1 0 0 1", c, bus.tlb_flush_req_o,
                 bus.csr_wr_en_o, bus.rsp_valid_o, bus.busy_o);
      end
      if (c == 4) bus.tlb_flush_ack_i = 1'b1;
      step();
      bus.tlb_flush_ack_i = 1'b0;
    end
`endif
    checks++;
    if (bus.tlb_flush_req_o !== 1'b0 || bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 32'h0 ||
        bus.rsp_illegal_o !== 1'b0 || bus.csr_wr_en_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rw_rsp: fl=%b rv=%b rd=%h ill=%b we=%b rdy=%b want 0 1 0 0 0 0", bus.tlb_flush_req_o,
               bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_illegal_o, bus.csr_wr_en_o, bus.req_ready_o);
    end
    finish_rsp();
    check_idle("rw_after");
  endtask

  task automatic run_rmw(input string tag, input logic [1:0] op, input logic [31:0] wd,
                         input logic [31:0] exp_w, input logic [31:0] exp_r);
    issue(op, 12'h180, wd);
    checks++;
    if (bus.csr_wr_en_o !== 1'b1 || bus.csr_wr_data_o !== exp_w) begin
      errors++;
      $display("FAIL %s_write: we=%b wd=%h want 1 %h", tag, bus.csr_wr_en_o, bus.csr_wr_data_o, exp_w);
    end
    bus.csr_satp_i = exp_w;
    step();
`ifdef CSR_CTRL_TLB_FLUSH_EN
    bus.tlb_flush_ack_i = 1'b1;   // ack in first FLUSH cycle
    step();
    bus.tlb_flush_ack_i = 1'b0;
`endif
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== exp_r || bus.tlb_flush_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_rsp: rv=%b rd=%h fl=%b want 1 %h 0", tag, bus.rsp_valid_o, bus.rsp_rdata_o, bus.tlb_flush_req_o, exp_r);
    end
    finish_rsp();
  endtask

  task automatic test_rs_rc();
    bus.csr_satp_i = 32'h0000_00F0;
    run_rmw("rs", 2'b10, 32'h0F, 32'h0000_00FF, 32'h0000_00F0);
    run_rmw("rc", 2'b11, 32'hF0, 32'h0000_000F, 32'h0000_00FF);
  endtask

  task automatic test_rs_zero();
    bus.csr_satp_i = 32'h0000_00FF;
    issue(2'b10, 12'h180, 32'h0);
    checks++;
    if (bus.csr_wr_en_o !== 1'b0 || bus.tlb_flush_req_o !== 1'b0 || bus.rsp_valid_o !== 1'b1 ||
        bus.rsp_rdata_o !== 32'h0000_00FF || bus.rsp_illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL rs_zero: we=%b fl=%b rv=%b rd=%h ill=%b want 0 0 1 000000ff 0", bus.csr_wr_en_o,
               bus.tlb_flush_req_o, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_illegal_o);
    end
    finish_rsp();
  endtask

  task automatic test_illegal();
    bus.csr_satp_i = 32'h1234_5678;
    bus.tlb_flush_ack_i = 1'b1;   // stray ack in IDLE
    step();
    bus.tlb_flush_ack_i = 1'b0;
    check_idle("stray_ack_idle");
    issue(2'b01, 12'h300, 32'hFFFF_FFFF);
    checks++;
    if (bus.csr_wr_en_o !== 1'b0 || bus.rsp_valid_o !== 1'b1 || bus.rsp_illegal_o !== 1'b1 || bus.rsp_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL ill_addr: we=%b rv=%b ill=%b rd=%h want 0 1 1 0", bus.csr_wr_en_o, bus.rsp_valid_o,
               bus.rsp_illegal_o, bus.rsp_rdata_o);
    end
    bus.tlb_flush_ack_i = 1'b1;   // stray ack in RESP
    step();
    bus.tlb_flush_ack_i = 1'b0;
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.rsp_illegal_o !== 1'b1 || bus.tlb_flush_req_o !== 1'b0) begin
      errors++;
      $display("FAIL ill_stray_resp: rv=%b ill=%b fl=%b want 1 1 0", bus.rsp_valid_o, bus.rsp_illegal_o, bus.tlb_flush_req_o);
    end
    finish_rsp();
    issue(2'b00, 12'h180, 32'h5);
    checks++;
    if (bus.csr_wr_en_o !== 1'b0 || bus.rsp_valid_o !== 1'b1 || bus.rsp_illegal_o !== 1'b1 || bus.rsp_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL ill_op: we=%b rv=%b ill=%b rd=%h want 0 1 1 0", bus.csr_wr_en_o, bus.rsp_valid_o,
               bus.rsp_illegal_o, bus.rsp_rdata_o);
    end
    finish_rsp();
    check_idle("ill_after");
  endtask

  task automatic test_backpressure();
    bus.csr_satp_i = 32'hA5A5_0001;
    issue(2'b11, 12'h180, 32'h0);
    bus.req_valid_i = 1'b1;        // competing request must not be taken
    bus.req_op_i    = 2'b01;
    bus.csr_satp_i  = 32'h0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 32'hA5A5_0001 || bus.req_ready_o !== 1'b0 ||
          bus.busy_o !== 1'b1 || bus.csr_wr_en_o !== 1'b0) begin
        errors++;
        $display("FAIL bp c%0d: rv=%b rd=%h rdy=%b busy=%b we=%b want 1 a5a50001 0 1 0", c, bus.rsp_valid_o,
                 bus.rsp_rdata_o, bus.req_ready_o, bus.busy_o, bus.csr_wr_en_o);
      end
      step();
    end
    bus.req_valid_i = 1'b0;
    finish_rsp();
    check_idle("bp_after");
  endtask

  task automatic test_reset_mid_flush();
    bus.csr_satp_i = 32'h0;
    issue(2'b01, 12'h180, 32'h0000_0042);
    step();                          // FLUSH (or RESP without flush)
    #2;
    rst_i = 1'b0;
    #1;
    check_idle("mid_rst");
    @(negedge clk_i); rst_i = 1'b1;
    bus.tlb_flush_ack_i = 1'b1;
    step();
    bus.tlb_flush_ack_i = 1'b0;
    step();
    check_idle("mid_rst_after");
  endtask

  initial begin
    bus.req_valid_i     = 1'b0;
    bus.req_op_i        = 2'b00;
    bus.req_addr_i      = 12'h0;
    bus.req_wdata_i     = 32'h0;
    bus.rsp_ready_i     = 1'b0;
    bus.csr_satp_i      = 32'h0;
    bus.tlb_flush_ack_i = 1'b0;
    test_reset();
    test_rw_flush();
    test_rs_rc();
    test_rs_zero();
    test_illegal();
    test_backpressure();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
